// File: rtl/cfd_cache_pkg.sv
// cfd_cache_pkg: shared state encoding and address-width default for the chunk sequencer.
package cfd_cache_pkg;
    localparam int ADDR_W_DEF = 12;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;
endpackage

// File: rtl/chunk_addr_counter.sv
// chunk_addr_counter: modulo-CHUNK_WORDS BRAM address counter with clear and wrap strobe.
module chunk_addr_counter #(
    parameter int ADDR_W      = 12,
    parameter int CHUNK_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              wrap_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CHUNK_WORDS - 1);
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    assign wrap_o = inc_i & (cnt_q == LAST);
    assign cnt_o  = cnt_q;
    always_comb cnt_d = (clr_i | wrap_o) ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/chunk_sequencer.sv
// chunk_sequencer: alternates BRAM chunks between DDR load and LBM compute phases.
// Optional CHUNK_CYCLE_COUNT_EN adds a saturating per-chunk compute cycle counter.
module chunk_sequencer
    import cfd_cache_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int CHUNK_WORDS = 4096,
    parameter int NUM_CHUNKS  = 16,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              lbm_done,
    output logic              wen,
    output logic [ADDR_W-1:0] DDR_addr,
    output logic              chunk_transfer_ready,
    output logic              chunk_compute_ready,
    output logic [IDX_W-1:0]  chunk_idx,
    output logic              busy,
`ifdef CHUNK_CYCLE_COUNT_EN
    output logic [31:0]       compute_cycles,
`endif
    output logic              frame_done
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap;
    assign pix_ready            = state_q == ST_LOAD;
    assign chunk_transfer_ready = state_q == ST_LOAD;
    assign chunk_compute_ready  = state_q == ST_COMPUTE;
    assign busy                 = state_q != ST_IDLE;
    assign frame_done           = state_q == ST_DONE;
    assign chunk_idx            = idx_q;
    // abort suppresses the write so a half-aborted beat never lands in BRAM
    assign wen = pix_ready & pix_valid & ~abort;

    chunk_addr_counter #(.ADDR_W(ADDR_W), .CHUNK_WORDS(CHUNK_WORDS)) u_addr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (wen),
        .clr_i (abort),
        .cnt_o (DDR_addr),
        .wrap_o(wrap)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = start ? ST_LOAD : ST_IDLE;
                    idx_d   = '0;
                end
                ST_LOAD: state_d = wrap ? ST_COMPUTE : ST_LOAD;
                ST_COMPUTE: if (lbm_done) begin
                    state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_LOAD;
                    idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

`ifdef CHUNK_CYCLE_COUNT_EN
    logic [31:0] cc_q, cc_d;
    assign compute_cycles = cc_q;
    always_comb cc_d = (state_q == ST_LOAD && state_d == ST_COMPUTE) ? 32'd0 :
                       (state_q == ST_COMPUTE && cc_q != 32'hFFFF_FFFF) ? cc_q + 32'd1 : cc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cc_q <= '0;
        else     cc_q <= cc_d;
    end
`endif
endmodule

// File: tb/tb_chunk_sequencer.sv
// tb_chunk_sequencer: directed plus randomized checks of chunk_sequencer against a phase-level model.
module tb_chunk_sequencer;
    localparam int AW = 12, CW = 4, NC = 2, IW = 8;
    logic clk = 1'b0;
    logic rst, start, abort, pix_valid, lbm_done;
    logic pix_ready, wen, ctr, ccr, busy, frame_done;
    logic [AW-1:0] ddr_addr;
    logic [IW-1:0] chunk_idx;
`ifdef CHUNK_CYCLE_COUNT_EN
    logic [31:0] compute_cycles;
`endif
    always #5 clk = ~clk;

    chunk_sequencer #(.ADDR_W(AW), .CHUNK_WORDS(CW), .NUM_CHUNKS(NC), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .lbm_done(lbm_done),
        .wen(wen), .DDR_addr(ddr_addr),
        .chunk_transfer_ready(ctr), .chunk_compute_ready(ccr),
        .chunk_idx(chunk_idx), .busy(busy),
`ifdef CHUNK_CYCLE_COUNT_EN
        .compute_cycles(compute_cycles),
`endif
        .frame_done(frame_done)
    );

    int compared = 0, mism = 0;
    // phase: 0 idle, 1 loading words, 2 computing, 3 frame finished
    int m_phase, m_words, m_chunk;
    longint m_cc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_words = 0; m_chunk = 0; m_cc = 0;
    endtask

    task automatic check_all(input string tag);
        logic loading;
        loading = (m_phase == 1);
        chk({tag, ".pix_ready"}, 32'(pix_ready), 32'(loading));
        chk({tag, ".wen"}, 32'(wen), 32'(loading && pix_valid && !abort));
        chk({tag, ".addr"}, 32'(ddr_addr), 32'(m_words));
        chk({tag, ".xfer_rdy"}, 32'(ctr), 32'(loading));
        chk({tag, ".comp_rdy"}, 32'(ccr), 32'(m_phase == 2));
        chk({tag, ".idx"}, 32'(chunk_idx), 32'(m_chunk));
        chk({tag, ".busy"}, 32'(busy), 32'(m_phase != 0));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_phase == 3));
        chk({tag, ".exclusive"}, 32'(ctr & ccr), 32'd0);
`ifdef CHUNK_CYCLE_COUNT_EN
        chk({tag, ".cc"}, compute_cycles, 32'(m_cc));
`endif
    endtask

    task automatic model_step();
        int old = m_phase;
        if (abort) begin
            m_phase = 0; m_words = 0; m_chunk = 0;
        end else if (m_phase == 0 && start) begin
            m_phase = 1; m_words = 0; m_chunk = 0;
        end else if (m_phase == 1 && pix_valid) begin
            m_words = (m_words + 1) % CW;
            if (m_words == 0) m_phase = 2;
        end else if (m_phase == 2 && lbm_done) begin
            if (m_chunk == NC - 1) m_phase = 3;
            else begin m_chunk++; m_phase = 1; end
        end else if (m_phase == 3) begin
            m_phase = 0; m_chunk = 0;
        end
        if (old == 1 && m_phase == 2) m_cc = 0;
        else if (old == 2 && m_cc < 64'hFFFF_FFFF) m_cc++;
    endtask

    task automatic tick(input logic s, input logic a, input logic pv, input logic ld, input string tag);
        @(negedge clk);
        start = s; abort = a; pix_valid = pv; lbm_done = ld;
        #1 check_all(tag);
        @(posedge clk);
        model_step();
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; pix_valid = 0; lbm_done = 0;
        model_reset();
        #12 check_all("reset");
        @(negedge clk) rst = 1'b0;
        // full two-chunk frame
        tick(1, 0, 0, 0, "t1_start");
        repeat (4) tick(0, 0, 1, 0, "t1_load0");
        repeat (2) tick(0, 0, 0, 0, "t1_comp0");
        tick(0, 0, 0, 1, "t1_done0");
        repeat (4) tick(0, 0, 1, 0, "t1_load1");
        tick(0, 0, 0, 1, "t1_done1");
        tick(0, 0, 0, 0, "t1_frame");
        tick(0, 0, 0, 0, "t1_idle");
        // stalled loading
        tick(1, 0, 0, 0, "t2_start");
        for (int i = 0; i < 8; i++) tick(0, 0, 1'(~i[0]), 0, "t2_toggle");
        // back-pressure during compute
        repeat (3) tick(0, 0, 1, 0, "t3_bp");
        tick(0, 0, 1, 1, "t3_done");
        // abort mid-load with a valid beat
        repeat (2) tick(0, 0, 1, 0, "t4_load");
        tick(0, 1, 1, 0, "t4_abort");
        tick(0, 0, 0, 0, "t4_after");
        // spurious start / lbm_done in load, then async reset in compute
        tick(1, 0, 0, 0, "t5_start");
        tick(1, 0, 1, 0, "t5_start_in_load");
        tick(0, 0, 1, 1, "t5_done_in_load");
        repeat (2) tick(0, 0, 1, 0, "t5_load");
        tick(0, 0, 1, 0, "t5_comp");
        @(negedge clk);
        start = 0; abort = 0; pix_valid = 1; lbm_done = 0;
        #3 rst = 1'b1;
        #1 model_reset();
        check_all("t5_async_rst");
        @(negedge clk) rst = 1'b0;
`ifdef CHUNK_CYCLE_COUNT_EN
        tick(1, 0, 0, 0, "t6_start");
        repeat (4) tick(0, 0, 1, 0, "t6_load");
        repeat (9) tick(0, 0, 0, 0, "t6_comp");
        tick(0, 0, 0, 1, "t6_done");
        tick(0, 0, 1, 0, "t6_hold");
        chk("t6_cc_literal", compute_cycles, 32'd10);
        tick(0, 1, 0, 0, "t6_abort");
`endif
        repeat (600)
            tick(($urandom_range(7) == 0), ($urandom_range(31) == 0),
                 1'($urandom_range(1)), ($urandom_range(3) == 0), "rand");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/chunk_sequencer.md
Name: chunk_sequencer

Overview:
Top-level chunk controller that drives the BRAM address-mux stage. It alternates each BRAM chunk between a transfer phase and a compute phase:
- Transfer phase: pixel words stream in from DDR and are written to BRAM at a sequential address.
- Compute phase: the LBM core owns the BRAM until it signals done.
It generates the chunk_transfer_ready / chunk_compute_ready selects, the write enable and the DDR-side BRAM address consumed downstream.

Parameters:
ADDR_W, 12, BRAM address width; matches the downstream 12-bit address.
CHUNK_WORDS, 4096, words per chunk; must satisfy 1 <= CHUNK_WORDS <= 2**ADDR_W.
NUM_CHUNKS, 16, chunks per frame; must be >= 1.
IDX_W, 8, width of chunk_idx; must satisfy 2**IDX_W >= NUM_CHUNKS.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; begins a frame; honoured only in IDLE.
abort  in  1  synchronous; returns to IDLE from any state next cycle.
pix_valid  in  1  DDR pixel word available.
pix_ready  out  1  sequencer accepts a word this cycle.
lbm_done  in  1  single-cycle pulse from the LBM core: chunk compute finished.
wen  out  1  BRAM write enable; combinational, equals pix_valid & pix_ready.
DDR_addr  out  ADDR_W  BRAM write address for the current transfer beat.
chunk_transfer_ready  out  1  high throughout LOAD.
chunk_compute_ready  out  1  high throughout COMPUTE.
chunk_idx  out  IDX_W  index of the chunk currently loading or computing.
busy  out  1  high in any state except IDLE.
frame_done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, DDR_addr=0, chunk_idx=0, and all 1-bit outputs are 0.
- States are IDLE, LOAD, COMPUTE, DONE. Encoding is binary and registered. Outputs decode from the registered state only, except wen, which is combinational.
- IDLE:
  - All outputs 0.
  - start=1 -> LOAD, with chunk_idx=0 and DDR_addr=0.
  - chunk_transfer_ready is high on the cycle after start.
- LOAD:
  - pix_ready=1 and chunk_transfer_ready=1.
  - Each beat with pix_valid=1 writes: wen=1 with the current DDR_addr in the same cycle, and DDR_addr increments on the following edge.
  - Beat accepted at DDR_addr=CHUNK_WORDS-1: DDR_addr wraps to 0 and the state goes to COMPUTE.
  - pix_valid=0 stalls with no address change.
  - lbm_done in LOAD is ignored.
- COMPUTE:
  - chunk_compute_ready=1, pix_ready=0, wen=0; incoming pixels are back-pressured.
  - On lbm_done: if chunk_idx==NUM_CHUNKS-1 -> DONE; else chunk_idx increments and the state goes to LOAD.
- DONE: frame_done=1 for exactly one cycle, then IDLE. chunk_idx resets to 0 on entry to IDLE.
- Exclusivity: chunk_transfer_ready and chunk_compute_ready are never high in the same cycle. Each handoff between them is one edge with no gap cycle.
- start outside IDLE is ignored.
- abort has priority over every other input:
  - Next state IDLE, DDR_addr=0, chunk_idx=0.
  - wen is forced to 0 in the abort cycle, even if pix_valid=1.
- Counter widths: DDR_addr wraps at CHUNK_WORDS, not at 2**ADDR_W. No arithmetic overflow is possible given the parameter constraints.

Optional Feature:
Macro CHUNK_CYCLE_COUNT_EN.
- Defined:
  - Adds output compute_cycles (32 bits).
  - It clears to 0 on each entry to COMPUTE and increments every cycle in COMPUTE, saturating at 32'hFFFFFFFF.
  - It holds its value outside COMPUTE until the next entry to COMPUTE.
  - Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cfd_cache_pkg holds:
  - the state encoding constants (ST_IDLE=2'd0, ST_LOAD=2'd1, ST_COMPUTE=2'd2, ST_DONE=2'd3);
  - the ADDR_W default of 12.
- One sub-module: chunk_addr_counter. It is a modulo-CHUNK_WORDS counter with inc and clr inputs and a wrap output, used for DDR_addr.

Test Plan:
1. CHUNK_WORDS=4, NUM_CHUNKS=2; start, then pix_valid held high -> wen high 4 cycles with DDR_addr 0,1,2,3. chunk_compute_ready rises on the edge after addr 3; lbm_done -> chunk_idx=1, LOAD again. Second lbm_done -> frame_done one cycle, then busy=0.
2. pix_valid toggling 1,0,1,0 in LOAD -> DDR_addr advances only on valid cycles; wen never high when pix_valid=0.
3. pix_valid=1 throughout COMPUTE -> pix_ready=0, wen=0, DDR_addr stays 0. Also check the two ready selects are never simultaneously 1 over the whole run.
4. abort asserted at DDR_addr=2 with pix_valid=1 -> wen=0 that cycle; next cycle state IDLE, DDR_addr=0, chunk_idx=0, busy=0.
5. rst asserted mid-COMPUTE between clock edges -> all outputs 0 immediately, without waiting for a clock edge. A start in LOAD or a spurious lbm_done in LOAD has no effect.
6. With CHUNK_CYCLE_COUNT_EN: lbm_done issued 10 cycles after COMPUTE entry -> compute_cycles=10, held through the following LOAD.
